// File: rtl/truth_table_scanner_if.sv
// -----------------------------------------------------------------------------
// truth_table_scanner_if
//
// Purpose:
//   Groups the control, stimulus and result signals of the truth-table scanner.
//   The scanner connects through the slave modport. The master side is the
//   controller that requests scans and reads results, together with the 3-input
//   logic block under scan, which drives f_in back from abc_out.
//
// Signals:
//   start          master -> slave  request a scan (accepted in IDLE or DONE)
//   expected[7:0]  master -> slave  expected truth table, bit i = F for code i
//   f_in           master -> slave  F output of the logic block under scan
//   abc_out[2:0]   slave -> master  drives {A,B,C}: [2]=A, [1]=B, [0]=C
//   busy           slave -> master  scan in progress
//   done           slave -> master  scan finished, results valid
//   truth_table    slave -> master  bit i = sampled F for code i
//   match          slave -> master  truth_table == captured expected
//   mismatch_count slave -> master  popcount(truth_table ^ captured expected)
// -----------------------------------------------------------------------------
interface truth_table_scanner_if;

    logic       start;
    logic [7:0] expected;
    logic       f_in;
    logic [2:0] abc_out;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;
    logic       match;
    logic [3:0] mismatch_count;

    modport master (
        output start,
        output expected,
        output f_in,
        input  abc_out,
        input  busy,
        input  done,
        input  truth_table,
        input  match,
        input  mismatch_count
    );

    modport slave (
        input  start,
        input  expected,
        input  f_in,
        output abc_out,
        output busy,
        output done,
        output truth_table,
        output match,
        output mismatch_count
    );

endinterface : truth_table_scanner_if

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
//
// Purpose:
//   Stimulus and capture stage for a 3-input combinational logic block.
//   Walks the input code {A,B,C} from 3'b000 up to 3'b111. Each code is held
//   for SETTLE_CYCLES clocks, and F is sampled on the last of those clocks.
//   The sampled bits form an 8-bit truth table. At the end of the scan this
//   table is compared against an expected table that was captured when the
//   scan started.
//
// Parameters:
//   SETTLE_CYCLES  clocks each code is held (legal range 1..255, default 4)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   truth_table_scanner_if.slave:
//         start, expected, f_in          (inputs)
//         abc_out, busy, done,
//         truth_table, match,
//         mismatch_count                 (registered outputs)
//
// Timing:
//   Let k be the edge that accepts start. Code i is sampled on edge
//   k + (i+1)*SETTLE_CYCLES. done, match and mismatch_count all become valid
//   on edge k + 8*SETTLE_CYCLES.
//   f_in has no internal synchronizer. The settle time must therefore cover
//   the path through the logic block.
// -----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter value on which the current code is sampled and the scan advances.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [7:0] settle_cnt;
    logic [7:0] expected_q;

    // Registered copies of the outputs.
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] table_q;
    logic       match_q;
    logic [3:0] mismatch_q;

    // Table with the current f_in merged in at the current code. On the final
    // sample edge this is the complete table, so match and mismatch_count can
    // be registered on the same edge as done.
    logic [7:0] sampled_table;
    logic [7:0] diff;
    logic [3:0] diff_ones;
    logic       sample_now;
    logic       accept_start;

    // NOTE: every variable written in a combinational block gets a default
    // assignment at the top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        sampled_table              = table_q;
        sampled_table[abc_q]       = bus.f_in;
        diff                       = sampled_table ^ expected_q;
        diff_ones                  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            diff_ones = diff_ones + 4'(diff[i]);
        end
    end

    assign sample_now   = (state == ST_SCAN) && (settle_cnt == SETTLE_LAST);
    // start is accepted only when no scan is running.
    assign accept_start = bus.start && (state != ST_SCAN);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments. Every register therefore updates from the values it had
    // before the edge, whatever order the statements are written in.
    // All registers, the truth table included, return to zero on reset. No
    // partial result survives a reset that arrives during a scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 8'd0;
            expected_q <= 8'h00;
            abc_q      <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= 8'h00;
            match_q    <= 1'b0;
            mismatch_q <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // In both states the scanner is idle and the outputs hold
                    // until start arrives. An accepted start in DONE restarts
                    // the scan exactly as an accepted start in IDLE does.
                    if (accept_start) begin
                        state      <= ST_SCAN;
                        settle_cnt <= 8'd0;
                        expected_q <= bus.expected;
                        abc_q      <= 3'b000;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        table_q    <= 8'h00;
                        match_q    <= 1'b0;
                        mismatch_q <= 4'd0;
                    end
                end

                ST_SCAN: begin
                    if (sample_now) begin
                        settle_cnt <= 8'd0;
                        table_q    <= sampled_table;
                        if (abc_q == 3'b111) begin
                            // This was the last code. abc_out stays at 3'b111.
                            state      <= ST_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            match_q    <= (sampled_table == expected_q);
                            mismatch_q <= diff_ones;
                        end else begin
                            abc_q <= abc_q + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.abc_out        = abc_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.truth_table    = table_q;
    assign bus.match          = match_q;
    assign bus.mismatch_count = mismatch_q;

endmodule : truth_table_scanner
